// File: rtl/rgb_stream_packer_if.sv
// Output pixel stream of the packer: valid/ready handshake with start-of-frame
// (tuser) and end-of-line (tlast) tags.
interface rgb_stream_packer_if #(
  parameter int PIXSIZE = 16
);
  logic                   m_tvalid;
  logic                   m_tready;
  logic [3*PIXSIZE-1:0]   m_tdata;
  logic                   m_tuser;
  logic                   m_tlast;

  modport master (output m_tvalid, m_tdata, m_tuser, m_tlast, input m_tready);
  modport slave  (input m_tvalid, m_tdata, m_tuser, m_tlast, output m_tready);
endinterface

// File: rtl/rgb_stream_packer.sv
// Converts the debayer frame/line-valid pixel bus into a tagged valid/ready stream
// through a FWFT FIFO, with geometry checking and sticky overflow/error flags.
module rgb_stream_packer #(
  parameter int PIXSIZE = 16,
  parameter int ROW_W   = 13,
  parameter int COL_W   = 14,
  parameter int FIFO_AW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   c_en,
  input  logic [ROW_W:0]         c_rows,
  input  logic [COL_W:0]         c_cols,
  input  logic                   frame_valid,
  input  logic                   line_valid,
  input  logic [3*PIXSIZE-1:0]   pixel_data,
  rgb_stream_packer_if.master    axis,
  output logic [FIFO_AW:0]       fifo_level,
  output logic [15:0]            frame_cnt,
  output logic                   ovf_o,
  output logic                   err_line_o,
  output logic                   err_frame_o
);
  localparam int DW    = 3 * PIXSIZE;
  localparam int WW    = DW + 2;
  localparam int DEPTH = 1 << FIFO_AW;

  logic [COL_W:0]       cols_m1, col_cnt;
  logic [ROW_W:0]       rows_m1, row_cnt, row_adv;
  logic [15:0]          frame_adv;
  logic                 fv_q, acc_q, line_open;
  logic                 stg_vld;
  logic [WW-1:0]        stg_word;
  logic [WW-1:0]        mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [WW-1:0]        head;
  logic                 accept, fv_fall, lv_fall, col_last, row_last, sof;
  logic                 full, pop, push;

  assign accept    = c_en & frame_valid & line_valid;
  assign fv_fall   = fv_q & ~frame_valid;
  assign lv_fall   = acc_q & frame_valid & ~line_valid;
  assign col_last  = (col_cnt == cols_m1);
  assign row_last  = (row_cnt == rows_m1);
  assign sof       = (row_cnt == '0) && (col_cnt == '0);
  assign row_adv   = row_last ? '0 : row_cnt + (ROW_W+1)'(1);
  assign frame_adv = row_last ? frame_cnt + 16'd1 : frame_cnt;

  assign full = (fifo_level == (FIFO_AW+1)'(DEPTH));
  assign pop  = axis.m_tvalid & axis.m_tready;
  // A pop on the same edge frees the slot the staged word needs.
  assign push = stg_vld & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      cols_m1     <= '0;
      rows_m1     <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      frame_cnt   <= '0;
      fv_q        <= 1'b0;
      acc_q       <= 1'b0;
      line_open   <= 1'b0;
      stg_vld     <= 1'b0;
      stg_word    <= '0;
      ovf_o       <= 1'b0;
      err_line_o  <= 1'b0;
      err_frame_o <= 1'b0;
    end else begin
      fv_q <= frame_valid;
      if (!c_en) begin
        cols_m1     <= c_cols - 1'b1;
        rows_m1     <= c_rows - 1'b1;
        col_cnt     <= '0;
        row_cnt     <= '0;
        frame_cnt   <= '0;
        acc_q       <= 1'b0;
        line_open   <= 1'b0;
        stg_vld     <= 1'b0;
        ovf_o       <= 1'b0;
        err_line_o  <= 1'b0;
        err_frame_o <= 1'b0;
      end else begin
        stg_vld <= accept;
        acc_q   <= accept;
        if (!line_valid) line_open <= 1'b0;
        if (stg_vld && full && !pop) ovf_o <= 1'b1;

        if (fv_fall) begin
          if (sof == 1'b0) begin
            err_frame_o <= 1'b1;
            col_cnt     <= '0;
            row_cnt     <= '0;
          end
        end else if (lv_fall) begin
          if (col_cnt != '0) begin
            err_line_o <= 1'b1;
            col_cnt    <= '0;
            row_cnt    <= row_adv;
            frame_cnt  <= frame_adv;
          end
        end else if (accept) begin
          stg_word  <= {sof, col_last, pixel_data};
          line_open <= 1'b1;
          // Pixel right after an eol pixel with no line gap: line was too long.
          if (col_cnt == '0 && line_open) err_line_o <= 1'b1;
          if (col_last) begin
            col_cnt   <= '0;
            row_cnt   <= row_adv;
            frame_cnt <= frame_adv;
          end else begin
            col_cnt <= col_cnt + (COL_W+1)'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !c_en) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (FIFO_AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (FIFO_AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stg_word;
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign head          = mem[rd_ptr];
  assign axis.m_tvalid = (fifo_level != '0);
  assign axis.m_tdata  = axis.m_tvalid ? head[DW-1:0] : '0;
  assign axis.m_tlast  = axis.m_tvalid & head[DW];
  assign axis.m_tuser  = axis.m_tvalid & head[DW+1];
endmodule

// File: tb/tb_rgb_stream_packer.sv
// Directed bench for rgb_stream_packer: geometry tagging, backpressure/overflow,
// line and frame errors, and flush on enable drop.
module tb_rgb_stream_packer;
  localparam int PS = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, c_en, frame_valid, line_valid;
  logic [13:0]   c_rows;
  logic [14:0]   c_cols;
  logic [47:0]   pixel_data;
  logic [AW:0]   fifo_level;
  logic [15:0]   frame_cnt;
  logic          ovf_o, err_line_o, err_frame_o;
  logic [49:0]   beats [$];
  int            checks = 0;
  int            errors = 0;

  rgb_stream_packer_if #(.PIXSIZE(PS)) axis ();

  rgb_stream_packer #(.PIXSIZE(PS), .ROW_W(13), .COL_W(14), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .c_en(c_en), .c_rows(c_rows), .c_cols(c_cols),
    .frame_valid(frame_valid), .line_valid(line_valid), .pixel_data(pixel_data),
    .axis(axis), .fifo_level(fifo_level), .frame_cnt(frame_cnt),
    .ovf_o(ovf_o), .err_line_o(err_line_o), .err_frame_o(err_frame_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (axis.m_tvalid === 1'b1 && axis.m_tready === 1'b1)
      beats.push_back({axis.m_tuser, axis.m_tlast, axis.m_tdata});

  function automatic logic [47:0] pix(input int v);
    logic [15:0] b;
    b = v[15:0];
    return {b, b + 16'h1000, b + 16'h2000};
  endfunction

  function automatic logic [49:0] mkbeat(input logic u, input logic l, input int v);
    return {u, l, pix(v)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input int rows, input int cols);
    c_en = 1'b0; frame_valid = 1'b0; line_valid = 1'b0;
    c_rows = 14'(rows); c_cols = 15'(cols);
    tick(); tick();
    c_en = 1'b1;
    tick();
    beats.delete();
  endtask

  task automatic send_pixels(input int n, input int v0);
    frame_valid = 1'b1; line_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      pixel_data = pix(v0 + i);
      tick();
    end
    line_valid = 1'b0; pixel_data = '0;
  endtask

  task automatic gap(input int n);
    line_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic end_frame();
    frame_valid = 1'b0; line_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; c_en = 1'b1; frame_valid = 1'b1; line_valid = 1'b1;
    pixel_data = pix(7); axis.m_tready = 1'b0;
    c_rows = 14'd1; c_cols = 15'd2;
    tick(); tick(); tick();
    checks++; if (axis.m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b exp 0", axis.m_tvalid); end
    checks++; if (axis.m_tdata !== 48'h0) begin errors++; $display("FAIL reset_tdata got %h exp 0", axis.m_tdata); end
    checks++; if ({axis.m_tuser, axis.m_tlast} !== 2'b00) begin errors++; $display("FAIL reset_tags got %b exp 00", {axis.m_tuser, axis.m_tlast}); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if ({ovf_o, err_line_o, err_frame_o} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {ovf_o, err_line_o, err_frame_o}); end
    rst = 1'b0; frame_valid = 1'b0; line_valid = 1'b0;
    tick();
  endtask

  task automatic test_clean_frame();
    logic [49:0] got, exp;
    axis.m_tready = 1'b1;
    configure(3, 4);
    frame_valid = 1'b1; line_valid = 1'b1; pixel_data = pix(0);
    tick();
    checks++; if (axis.m_tvalid !== 1'b0) begin errors++; $display("FAIL clean_latency1 tvalid got %0b exp 0", axis.m_tvalid); end
    pixel_data = pix(1);
    tick();
    checks++; if (axis.m_tvalid !== 1'b1) begin errors++; $display("FAIL clean_latency2 tvalid got %0b exp 1", axis.m_tvalid); end
    send_pixels(2, 2); gap(2);
    send_pixels(4, 4); gap(2);
    send_pixels(4, 8);
    end_frame(); gap(4);
    checks++; if (beats.size() != 12) begin errors++; $display("FAIL clean_count got %0d exp 12", beats.size()); end
    for (int i = 0; i < 12; i++) begin
      exp = mkbeat(i == 0, (i % 4) == 3, i);
      got = (i < beats.size()) ? beats[i] : 'x;
      checks++; if (got !== exp) begin errors++; $display("FAIL clean_beat%0d got %h exp %h", i, got, exp); end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL clean_frame_cnt got %0d exp 1", frame_cnt); end
    checks++; if ({ovf_o, err_line_o, err_frame_o} !== 3'b000) begin errors++; $display("FAIL clean_flags got %b exp 000", {ovf_o, err_line_o, err_frame_o}); end
  endtask

  task automatic test_backpressure();
    logic [49:0] got, exp;
    axis.m_tready = 1'b0;
    configure(2, 8);
    send_pixels(5, 'h100);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level_full got %0d exp 4", fifo_level); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL bp_ovf_early got %0b exp 0", ovf_o); end
    send_pixels(3, 'h105); gap(1);
    send_pixels(8, 'h108);
    end_frame();
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL bp_ovf got %0b exp 1", ovf_o); end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level_sat got %0d exp 4", fifo_level); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL bp_frame_cnt got %0d exp 1", frame_cnt); end
    beats.delete();
    axis.m_tready = 1'b1;
    gap(8);
    checks++; if (beats.size() != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", beats.size()); end
    for (int i = 0; i < 4; i++) begin
      exp = mkbeat(i == 0, 1'b0, 'h100 + i);
      got = (i < beats.size()) ? beats[i] : 'x;
      checks++; if (got !== exp) begin errors++; $display("FAIL bp_beat%0d got %h exp %h", i, got, exp); end
    end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL bp_level_drained got %0d exp 0", fifo_level); end
  endtask

  task automatic test_short_line();
    int v [7] = '{'h200, 'h201, 'h202, 'h210, 'h211, 'h212, 'h213};
    logic [49:0] got, exp;
    axis.m_tready = 1'b1;
    configure(2, 4);
    send_pixels(3, 'h200); gap(2);
    checks++; if (err_line_o !== 1'b1) begin errors++; $display("FAIL short_line_flag got %0b exp 1", err_line_o); end
    send_pixels(4, 'h210);
    end_frame(); gap(3);
    checks++; if (beats.size() != 7) begin errors++; $display("FAIL short_line_count got %0d exp 7", beats.size()); end
    for (int i = 0; i < 7; i++) begin
      exp = mkbeat(i == 0, i == 6, v[i]);
      got = (i < beats.size()) ? beats[i] : 'x;
      checks++; if (got !== exp) begin errors++; $display("FAIL short_line_beat%0d got %h exp %h", i, got, exp); end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL short_line_frame_cnt got %0d exp 1", frame_cnt); end
    checks++; if (err_frame_o !== 1'b0) begin errors++; $display("FAIL short_line_err_frame got %0b exp 0", err_frame_o); end
  endtask

  task automatic test_long_line();
    logic [49:0] got, exp;
    axis.m_tready = 1'b1;
    configure(3, 4);
    send_pixels(4, 'h300);
    checks++; if (err_line_o !== 1'b0) begin errors++; $display("FAIL long_line_early got %0b exp 0", err_line_o); end
    send_pixels(1, 'h304);
    checks++; if (err_line_o !== 1'b1) begin errors++; $display("FAIL long_line_flag got %0b exp 1", err_line_o); end
    gap(4);
    checks++; if (beats.size() != 5) begin errors++; $display("FAIL long_line_count got %0d exp 5", beats.size()); end
    for (int i = 0; i < 5; i++) begin
      exp = mkbeat(i == 0, i == 3, 'h300 + i);
      got = (i < beats.size()) ? beats[i] : 'x;
      checks++; if (got !== exp) begin errors++; $display("FAIL long_line_beat%0d got %h exp %h", i, got, exp); end
    end
    end_frame();
  endtask

  task automatic test_short_frame();
    logic [49:0] got, exp;
    axis.m_tready = 1'b1;
    configure(3, 4);
    send_pixels(4, 'h400); gap(2);
    send_pixels(4, 'h410); gap(1);
    end_frame();
    checks++; if (err_frame_o !== 1'b1) begin errors++; $display("FAIL short_frame_flag got %0b exp 1", err_frame_o); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL short_frame_cnt got %0d exp 0", frame_cnt); end
    gap(2);
    beats.delete();
    send_pixels(4, 'h420);
    gap(4);
    checks++; if (beats.size() != 4) begin errors++; $display("FAIL short_frame_count got %0d exp 4", beats.size()); end
    for (int i = 0; i < 4; i++) begin
      exp = mkbeat(i == 0, i == 3, 'h420 + i);
      got = (i < beats.size()) ? beats[i] : 'x;
      checks++; if (got !== exp) begin errors++; $display("FAIL short_frame_beat%0d got %h exp %h", i, got, exp); end
    end
    checks++; if (err_line_o !== 1'b0) begin errors++; $display("FAIL short_frame_err_line got %0b exp 0", err_line_o); end
    end_frame();
  endtask

  task automatic test_flush();
    logic [49:0] got, exp;
    axis.m_tready = 1'b0;
    configure(2, 4);
    send_pixels(3, 'h500); gap(1);
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL flush_pre_level got %0d exp 3", fifo_level); end
    checks++; if (err_line_o !== 1'b1) begin errors++; $display("FAIL flush_pre_err_line got %0b exp 1", err_line_o); end
    c_en = 1'b0; frame_valid = 1'b0; line_valid = 1'b0;
    c_rows = 14'd2; c_cols = 15'd6;
    tick();
    checks++; if (axis.m_tvalid !== 1'b0) begin errors++; $display("FAIL flush_tvalid got %0b exp 0", axis.m_tvalid); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL flush_level got %0d exp 0", fifo_level); end
    checks++; if ({ovf_o, err_line_o, err_frame_o} !== 3'b000) begin errors++; $display("FAIL flush_flags got %b exp 000", {ovf_o, err_line_o, err_frame_o}); end
    tick();
    c_en = 1'b1; axis.m_tready = 1'b1;
    tick();
    beats.delete();
    send_pixels(6, 'h600); gap(2);
    send_pixels(6, 'h610);
    end_frame(); gap(3);
    checks++; if (beats.size() != 12) begin errors++; $display("FAIL flush_count got %0d exp 12", beats.size()); end
    for (int i = 0; i < 12; i++) begin
      exp = mkbeat(i == 0, (i % 6) == 5, (i < 6) ? 'h600 + i : 'h610 + i - 6);
      got = (i < beats.size()) ? beats[i] : 'x;
      checks++; if (got !== exp) begin errors++; $display("FAIL flush_beat%0d got %h exp %h", i, got, exp); end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL flush_frame_cnt got %0d exp 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_backpressure();
    test_short_line();
    test_long_line();
    test_short_frame();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb_stream_packer.md
# rgb_stream_packer

Output stage placed directly downstream of the debayer block. It consumes the debayer's frame_valid/line_valid/RGB pixel bus and converts it into a valid/ready stream with start-of-frame (tuser) and end-of-line (tlast) tags. A small first-word-fall-through FIFO absorbs downstream backpressure. The block also checks line and frame geometry against the programmed size and reports overflow and geometry errors as sticky flags.

## Interface
- PIXSIZE, 16, bits per colour component
- ROW_W, 13, row-count width minus one (c_rows is ROW_W+1 bits)
- COL_W, 14, column-count width minus one (c_cols is COL_W+1 bits)
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- c_en  in  1  enable; while low, c_rows/c_cols are latched, the FIFO is flushed, and counters and flags are cleared
- c_rows  in  ROW_W+1  lines per frame (≥1)
- c_cols  in  COL_W+1  pixels per line (≥2)
- frame_valid  in  1  frame qualifier from debayer
- line_valid  in  1  line qualifier from debayer
- pixel_data  in  3*PIXSIZE  RGB pixel; [3P-1:2P] first component, [2P-1:P] green, [P-1:0] last component
- m_tready  in  1  downstream ready
- m_tvalid  out  1  FIFO not empty
- m_tdata  out  3*PIXSIZE  pixel at FIFO head
- m_tuser  out  1  head pixel is row 0, col 0
- m_tlast  out  1  head pixel is the last column of its line
- fifo_level  out  FIFO_AW+1  current occupancy
- frame_cnt  out  16  frames completed (wraps)
- ovf_o  out  1  sticky: pixel dropped because FIFO was full
- err_line_o  out  1  sticky: short or long line detected
- err_frame_o  out  1  sticky: frame_valid fell before the frame was complete

## Operation
- Config: while c_en=0, register cols_m1 = c_cols-1 and rows_m1 = c_rows-1. The registered values are frozen while c_en=1.
- Accept: a pixel is accepted on an edge where c_en & frame_valid & line_valid.
- Counters: col_cnt (COL_W+1 bits) and row_cnt (ROW_W+1 bits).
  - On an accepted pixel at col_cnt==cols_m1: col_cnt wraps to 0 and row_cnt increments.
  - If row_cnt also equals rows_m1: row_cnt wraps to 0 and frame_cnt increments.
- Tags: sof = (row_cnt==0 && col_cnt==0); eol = (col_cnt==cols_m1). Both are evaluated before the counters update.
- Stage register: each accepted pixel is registered as {sof, eol, data}. One cycle later it is written into the FIFO.
- FIFO write:
  - Allowed if not full, or if a pop occurs on the same edge.
  - Otherwise the word is dropped and ovf_o is set. Counters still advance, so geometry stays locked.
- FIFO read: pop when m_tvalid & m_tready. Outputs show the head word combinationally from FIFO storage (FWFT).
- Short line: line_valid falls inside frame_valid (previous cycle accepted, now frame_valid=1, line_valid=0) with col_cnt≠0.
  - Set err_line_o, force col_cnt to 0, increment row_cnt (same wrap rules as above).
- Long line:
  - A flag line_open is set on each accepted pixel and cleared on a line_valid fall.
  - An accepted pixel at col_cnt==0 with line_open=1 (an eol pixel was followed without a gap) sets err_line_o. The pixel is still processed normally.
- Short frame: frame_valid falls (1→0) while row_cnt≠0 or col_cnt≠0.
  - Set err_frame_o and reset both counters to 0. frame_cnt does not increment.
- Precedence on one edge: c_en=0 overrides everything; then frame_valid fall; then line_valid fall; then accept.
- Sticky flags clear only on rst or c_en=0.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, fifo_level=0, frame_cnt=0, ovf_o=0, err_line_o=0, err_frame_o=0. Counters, line_open and the stage register are 0. cols_m1/rows_m1 are 0.
- Latency: a pixel sampled on edge k is written to the FIFO on edge k+1. If the FIFO was empty, m_tvalid=1 after edge k+1.
- Throughput: one pixel per clock sustained while m_tready=1.
- FIFO level:
  - Simultaneous write and pop leave fifo_level unchanged.
  - When full, a pop on the same edge permits the write.
  - When empty, no pop is possible.
- Stability: m_tdata/m_tuser/m_tlast stay stable while m_tvalid=1 and m_tready=0.
- Pointers: read/write pointers wrap modulo 2^FIFO_AW. Full = level==2^FIFO_AW.
- Flush: c_en falling takes effect on the next edge. The FIFO empties (m_tvalid=0) and the in-flight stage word is discarded.
- Mid-operation rst: identical to power-on reset on the next edge. No partial word is emitted.
- Flag timing: each sticky flag asserts on the edge following the detecting event.

## Test plan
- Clean frame, 4x3, m_tready=1, c_en=1 after config → 12 beats in order. tuser only on beat 0. tlast on beats 3, 7, 11. frame_cnt=1. No flags. First m_tvalid 2 cycles after first accepted pixel.
- FIFO_AW=2, 8x2 frame, m_tready=0 throughout → fifo_level saturates at 4. ovf_o=1 from the 5th pixel. Releasing m_tready yields exactly the first 4 pixels. frame_cnt=1.
- Short line: c_cols=4, line 0 has 3 pixels then line_valid drops → err_line_o=1. The next pixel has col 0 and row 1 (tuser=0), and its tlast falls after 4 pixels.
- Long line: c_cols=4, 5 pixels in one line_valid burst → err_line_o=1. The 5th pixel is tagged col 0 (tlast=0); beat 3 has tlast=1.
- Short frame: c_rows=3, frame_valid drops after 2 full lines → err_frame_o=1, frame_cnt=0. The next frame's first pixel carries tuser=1.
- Mid-frame c_en=0 with 3 words in the FIFO → next cycle m_tvalid=0, fifo_level=0, all flags 0. Re-enable with a new c_cols=6 → tlast every 6 beats.
